// File: rtl/run_ctrl_pkg.sv
// Shared state encoding for the datapath run/step/halt controller.
package run_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and
// a one-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // Level is accepted once the synchronised input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts the count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        pulse_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/datapath_run_ctrl.sv
// Run/step/halt controller issuing one-cycle datapath advance enables and
// latching display coordinates. Optional breakpoint: RUN_CTRL_BREAKPOINT_EN.
module datapath_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DIV_COUNT       = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               RunSw,
  input  logic               StepBtn,
  input  logic               HaltReq,
  input  logic [31:0]        PcIn,
  input  logic [31:0]        BreakAddr,
  input  logic [15:0]        XIn,
  input  logic [15:0]        YIn,
  output logic               ClkEn,
  output logic [15:0]        XDisp,
  output logic [15:0]        YDisp,
  output logic [STATE_W-1:0] State,
  output logic [31:0]        AdvCount
);

  localparam int unsigned      TICK_W    = $clog2(DIV_COUNT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_COUNT - 1);

  state_e            state_q;
  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_wrap;
  logic              clk_en_q;
  logic              disp_pend_q;
  logic [15:0]       xdisp_q;
  logic [15:0]       ydisp_q;
  logic [31:0]       adv_q;
  logic              step_pulse;
  logic              bp_hit;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .Clk    (Clk),
    .Reset  (Reset),
    .btn_i  (StepBtn),
    .pulse_o(step_pulse)
  );

`ifdef RUN_CTRL_BREAKPOINT_EN
  assign bp_hit = (PcIn == BreakAddr);
`else
  logic unused_bp;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{PcIn, BreakAddr};
`endif

  assign tick_wrap = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);

  // ClkEn is registered, so a due advance is decided one cycle early; halt and
  // breakpoint are evaluated in that deciding cycle and suppress the advance.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      clk_en_q    <= 1'b0;
      disp_pend_q <= 1'b0;
      xdisp_q     <= '0;
      ydisp_q     <= '0;
      adv_q       <= '0;
    end else begin
      clk_en_q    <= 1'b0;
      tick_q      <= '0;
      disp_pend_q <= clk_en_q;
      if (disp_pend_q) begin
        xdisp_q <= XIn;
        ydisp_q <= YIn;
      end
      if (clk_en_q && (adv_q != 32'hFFFF_FFFF)) begin
        adv_q <= adv_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          if (RunSw) begin
            state_q <= RUN;
          end else if (step_pulse) begin
            state_q  <= STEP;
            clk_en_q <= 1'b1;
          end
        end
        RUN: begin
          if (HaltReq) begin
            state_q <= HALT;
          end else if (!RunSw) begin
            state_q <= IDLE;
          end else begin
            tick_q <= tick_wrap;
            if (tick_wrap == TICK_LAST) begin
              if (bp_hit) begin
                state_q <= HALT;
              end else begin
                clk_en_q <= 1'b1;
              end
            end
          end
        end
        STEP: state_q <= IDLE;
        HALT: begin
          if (!RunSw && !HaltReq) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ClkEn    = clk_en_q;
  assign XDisp    = xdisp_q;
  assign YDisp    = ydisp_q;
  assign State    = state_q;
  assign AdvCount = adv_q;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Bench for datapath_run_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_datapath_run_ctrl;

  localparam int DIV = 4;
  localparam int DC  = 3;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        RunSw = 1'b0;
  logic        StepBtn = 1'b0;
  logic        HaltReq = 1'b0;
  logic [31:0] PcIn = 32'd0;
  logic [31:0] BreakAddr = 32'hDEAD_BEEF;
  logic [15:0] XIn = 16'd0;
  logic [15:0] YIn = 16'd0;
  logic        ClkEn;
  logic [15:0] XDisp;
  logic [15:0] YDisp;
  logic [1:0]  State;
  logic [31:0] AdvCount;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  datapath_run_ctrl #(
    .DIV_COUNT(DIV),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .Clk(clk), .Reset(Reset), .RunSw(RunSw), .StepBtn(StepBtn), .HaltReq(HaltReq),
    .PcIn(PcIn), .BreakAddr(BreakAddr), .XIn(XIn), .YIn(YIn),
    .ClkEn(ClkEn), .XDisp(XDisp), .YDisp(YDisp), .State(State), .AdvCount(AdvCount)
  );

  always #5 clk = ~clk;

  // Behavioural model: state codes 0 idle, 1 run, 2 step, 3 halt; RUN advances
  // whenever the number of cycles since entry is a multiple of DIV.
  typedef struct {
    int          st;
    int          age;
    bit          clken;
    bit          clken_prev;
    logic [31:0] adv;
    logic [15:0] x;
    logic [15:0] y;
    bit          pulse;
    bit          lvl;
    int          disagree;
    bit [1:0]    raw;
  } model_t;

  model_t m;

  function automatic model_t step_model(model_t c, bit rst, bit run_sw, bit btn, bit halt,
                                        logic [31:0] pc, logic [31:0] bpa,
                                        logic [15:0] xi, logic [15:0] yi);
    model_t n;
    bit s2;
    bit bp;
    n = c;
    if (rst) begin
      n.st = 0; n.age = 0; n.clken = 0; n.clken_prev = 0; n.adv = 0;
      n.x = 0; n.y = 0; n.pulse = 0; n.lvl = 0; n.disagree = 0; n.raw = 2'b00;
      return n;
    end
`ifdef RUN_CTRL_BREAKPOINT_EN
    bp = (pc == bpa);
`else
    bp = 1'b0;
`endif
    if (c.clken_prev) begin
      n.x = xi;
      n.y = yi;
    end
    if (c.clken && c.adv != 32'hFFFF_FFFF) n.adv = c.adv + 1;
    n.clken_prev = c.clken;
    n.clken = 0;
    case (c.st)
      0: if (run_sw) begin n.st = 1; n.age = 1; end
         else if (c.pulse) begin n.st = 2; n.clken = 1; end
      1: if (halt) n.st = 3;
         else if (!run_sw) n.st = 0;
         else begin
           n.age = c.age + 1;
           if (n.age % DIV == 0) begin
             if (bp) n.st = 3;
             else n.clken = 1;
           end
         end
      2: n.st = 0;
      default: if (!run_sw && !halt) n.st = 0;
    endcase
    // Button sample seen by the debouncer is the raw input two edges old.
    s2 = c.raw[1];
    n.raw = {c.raw[0], btn};
    n.pulse = 0;
    if (s2 != c.lvl) begin
      n.disagree = c.disagree + 1;
      if (n.disagree == DC) begin
        n.lvl = s2;
        n.pulse = s2;
        n.disagree = 0;
      end
    end else begin
      n.disagree = 0;
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= step_model(m, Reset, RunSw, StepBtn, HaltReq, PcIn, BreakAddr, XIn, YIn);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_state", 32'(State), 32'(m.st));
      chk("model_clken", 32'(ClkEn), 32'(m.clken));
      chk("model_adv", AdvCount, m.adv);
      chk("model_xdisp", 32'(XDisp), 32'(m.x));
      chk("model_ydisp", 32'(YDisp), 32'(m.y));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    RunSw = 1'b0; StepBtn = 1'b0; HaltReq = 1'b0; PcIn = 32'd0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    int cnt;
    do_reset();
    chk_en = 1'b1;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_clken", 32'(ClkEn), 32'd0);
    chk("rst_adv", AdvCount, 32'd0);
    chk("rst_xdisp", 32'(XDisp), 32'd0);
    chk("rst_ydisp", 32'(YDisp), 32'd0);

    // 1: free run, advances at cycles 4, 8, 12
    XIn = 16'h1234; YIn = 16'h00AB; RunSw = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("run_clken_c%0d", k), 32'(ClkEn), 32'((k % 4) == 0));
      if (k == 5) chk("run_xdisp_c5", 32'(XDisp), 32'h0);
      if (k == 6) begin
        chk("run_xdisp_c6", 32'(XDisp), 32'h1234);
        chk("run_ydisp_c6", 32'(YDisp), 32'h00AB);
      end
    end
    chk("run_adv_c13", AdvCount, 32'd3);

    // 2: held button gives one step; short glitch gives none
    do_reset();
    StepBtn = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 21) StepBtn = 1'b0;
      tick();
      cnt += int'(ClkEn);
    end
    chk("step_count", 32'(cnt), 32'd1);
    chk("step_adv", AdvCount, 32'd1);
    chk("step_state", 32'(State), 32'd0);
    cnt = 0;
    StepBtn = 1'b1;
    tick(); cnt += int'(ClkEn);
    tick(); cnt += int'(ClkEn);
    StepBtn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      cnt += int'(ClkEn);
    end
    chk("glitch_count", 32'(cnt), 32'd0);

    // 3: halt request on the deciding cycle suppresses the advance
    do_reset();
    RunSw = 1'b1;
    tick(); tick(); tick();
    HaltReq = 1'b1;
    tick();
    chk("halt_clken", 32'(ClkEn), 32'd0);
    chk("halt_state", 32'(State), 32'd3);
    tick();
    chk("halt_adv", AdvCount, 32'd0);
    RunSw = 1'b0;
    tick();
    chk("halt_hold", 32'(State), 32'd3);
    HaltReq = 1'b0;
    tick();
    chk("halt_exit", 32'(State), 32'd0);

    // 4: breakpoint at the fetch PC
    do_reset();
    BreakAddr = 32'h10; PcIn = 32'h10; RunSw = 1'b1;
    tick(); tick(); tick(); tick();
`ifdef RUN_CTRL_BREAKPOINT_EN
    chk("bp_state", 32'(State), 32'd3);
    chk("bp_clken", 32'(ClkEn), 32'd0);
    tick();
    chk("bp_adv", AdvCount, 32'd0);
`else
    chk("bp_state", 32'(State), 32'd1);
    chk("bp_clken", 32'(ClkEn), 32'd1);
    tick();
    chk("bp_adv", AdvCount, 32'd1);
`endif
    BreakAddr = 32'hDEAD_BEEF;

    // 5: run switch wins over a coincident step pulse (pulse lands in cycle 5)
    do_reset();
    StepBtn = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    RunSw = 1'b1;
    tick();
    chk("prio_state", 32'(State), 32'd1);
    chk("prio_clken", 32'(ClkEn), 32'd0);
    tick(); tick(); tick();
    chk("prio_clken_c9", 32'(ClkEn), 32'd1);
    tick();
    chk("prio_adv", AdvCount, 32'd1);
    StepBtn = 1'b0;

    // 6: reset mid-run drops the pending advance
    do_reset();
    XIn = 16'h5A5A;
    RunSw = 1'b1;
    tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_rst_state", 32'(State), 32'd0);
    chk("mid_rst_clken", 32'(ClkEn), 32'd0);
    chk("mid_rst_adv", AdvCount, 32'd0);
    for (int k = 4; k <= 7; k++) begin
      tick();
      chk($sformatf("mid_rst_clken_c%0d", k), 32'(ClkEn), 32'(k == 7));
    end

    // Randomized traffic against the model
    do_reset();
    BreakAddr = 32'h10;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) RunSw = ~RunSw;
      if ($urandom_range(0, 5) == 0) StepBtn = ~StepBtn;
      if (HaltReq) HaltReq = ($urandom_range(0, 2) != 0);
      else HaltReq = ($urandom_range(0, 49) == 0);
      PcIn = 32'($urandom_range(0, 31));
      XIn = 16'($urandom);
      YIn = 16'($urandom);
      Reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    Reset = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_run_ctrl.md
# datapath_run_ctrl

Run/step/halt controller for the pipelined datapath on the board top level. Replaces the free-running divided clock: the datapath and this block share the single board clock `Clk`, and the datapath advances only on cycles where `ClkEn` is high. The block also latches the datapath's X/Y coordinate outputs into stable display registers after each advance, so the 7-segment driver never shows mid-update values.

## Interface
- `DIV_COUNT`, default 100_000_000: `Clk` cycles between advances in RUN mode; minimum 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles `StepBtn` must be stable before a level change is accepted; minimum 1.
- `Clk`  in  1  board clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `RunSw`  in  1  level: 1 = free-run, 0 = stopped; already synchronised.
- `StepBtn`  in  1  raw push button; single-step request.
- `HaltReq`  in  1  level from datapath, e.g. halt instruction retired.
- `PcIn`  in  32  datapath fetch PC; breakpoint compare.
- `BreakAddr`  in  32  breakpoint address.
- `XIn`, `YIn`  in  16 each  live datapath coordinates.
- `ClkEn`  out  1  one-cycle datapath advance enable.
- `XDisp`, `YDisp`  out  16 each  latched coordinates for the display.
- `State`  out  2  current state encoding.
- `AdvCount`  out  32  number of advances issued; saturates at 0xFFFF_FFFF.

## Operation
- States: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALT=2'b11.
- IDLE:
  - `RunSw`=1 -> RUN, with the tick counter cleared.
  - Otherwise, a step pulse -> STEP.
  - `RunSw` has priority over a simultaneous step pulse.
- RUN:
  - Tick counter counts 0..DIV_COUNT-1 and wraps.
  - At terminal count, `ClkEn`=1 for one cycle.
  - `HaltReq`=1 on any cycle -> HALT; a `ClkEn` due in that cycle is suppressed.
  - Else `RunSw`=0 -> IDLE; no further `ClkEn`.
- STEP: `ClkEn`=1 for exactly one cycle, then -> IDLE. `RunSw`, `HaltReq` and the breakpoint are not checked in STEP.
- HALT:
  - No `ClkEn`.
  - -> IDLE only when `RunSw`=0 and `HaltReq`=0 in the same cycle.
- Step pulses arriving in RUN, STEP or HALT are discarded, not queued.
- Step pulse: the debounced `StepBtn` level goes 0->1. It is one cycle wide. Holding the button gives a single pulse.
- Display latch: `XDisp`/`YDisp` load `XIn`/`YIn` in the cycle after each `ClkEn`, i.e. once the datapath has updated.
- `AdvCount` increments on every `ClkEn` cycle.

## Timing
- Reset values:
  - `State`=IDLE, `ClkEn`=0, `XDisp`=`YDisp`=0, `AdvCount`=0.
  - Tick counter=0; debouncer level=0 and stable counter=0.
- Every output is a register; there are no combinational input-to-output paths.
- RUN entry at cycle t:
  - First `ClkEn` at cycle t+DIV_COUNT.
  - Then one `ClkEn` every DIV_COUNT cycles.
- Step pulse at cycle t in IDLE: State=STEP and `ClkEn`=1 at t+1; State=IDLE at t+2.
- Button to pulse: a press stable for DEBOUNCE_CYCLES produces the step pulse DEBOUNCE_CYCLES+2 cycles after the first stable sample, including 2 synchroniser flops.
- `ClkEn` at cycle t: display registers update at the edge ending cycle t+1.
- Reset asserted mid-operation: all state is cleared at the next edge. A `ClkEn` pending in the counter is lost.

## Configuration
- `RUN_CTRL_BREAKPOINT_EN` defined:
  - In RUN, if a `ClkEn` is due and `PcIn`==`BreakAddr`, that `ClkEn` is suppressed and State -> HALT.
  - The instruction at `BreakAddr` is not fetched.
  - STEP may advance past the breakpoint.
- `RUN_CTRL_BREAKPOINT_EN` undefined:
  - `PcIn` and `BreakAddr` stay on the port list but are ignored.
  - No comparator is synthesised.

## Structure
- Shared package/include `run_ctrl_pkg` holds the state localparams (IDLE, RUN, STEP, HALT) and the state width.
- One sub-module, `btn_debounce`:
  - Contains the 2-flop synchroniser, the stable counter and rising-edge pulse generation.
  - Parameterised by DEBOUNCE_CYCLES.
- FSM, tick counter, advance counter and display latch all sit in `datapath_run_ctrl`.

## Test plan
Bench parameters: DIV_COUNT=4, DEBOUNCE_CYCLES=3.

1. Reset, then `RunSw`=1 at cycle 0: `ClkEn` pulses at cycles 4, 8, 12. `AdvCount`=3 at cycle 13. `XDisp` takes `XIn`=0x1234 the cycle after each pulse.
2. `RunSw`=0, `StepBtn` held high for 20 cycles: exactly one `ClkEn`, `AdvCount`=1, State returns to IDLE. A 2-cycle glitch on `StepBtn` gives no `ClkEn`.
3. RUN with `HaltReq`=1 on the cycle a tick is due: no `ClkEn` on that cycle; State=HALT. With `RunSw`=0 and `HaltReq`=0: State=IDLE next cycle.
4. Breakpoint, macro defined, `BreakAddr`=0x10, `PcIn`=0x10 in RUN: State=HALT, `AdvCount` unchanged. Same stimulus with the macro undefined: `ClkEn` issues normally.
5. `RunSw` 0->1 and step pulse in the same IDLE cycle: State=RUN, no STEP `ClkEn`.
6. `Reset` pulsed 2 cycles after RUN entry: all outputs return to reset values. No `ClkEn` until 4 cycles after `RunSw` is next seen high.
